// File: rtl/jtframe_sdm_dac.sv
// Multi-channel first-order sigma-delta 1-bit audio DAC with a soft-mute gain ramp.
// Optional build macro JTFRAME_SDM_DITHER_EN adds LFSR carry-in dither to every accumulator.
module jtframe_sdm_dac #(
  parameter int CH         = 2,
  parameter int DW         = 16,
  parameter int SIGNED_SND = 1,
  parameter int GW         = 8,
  parameter int RAMP_DIV   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_cen,
  input  logic [CH*DW-1:0]   snd_in,
  input  logic               mute,
  output logic [CH-1:0]      dac_out,
  output logic               muted,
  output logic               ramping
);

  localparam int              DIVW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(RAMP_DIV - 1);
  localparam logic [DIVW-1:0] DIV_ONE   = DIVW'(1);
  localparam logic [GW:0]     GAIN_ZERO = '0;
  localparam logic [GW:0]     GAIN_ONE  = (GW+1)'(1);
  localparam logic [GW:0]     GAIN_FULL = {1'b1, {GW{1'b0}}};
  localparam logic [GW:0]     GAIN_TOP  = GAIN_FULL - GAIN_ONE;
  localparam logic [DW-1:0]   MID       = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]   SIGN_FLIP = (SIGNED_SND != 0) ? MID : '0;

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_PLAY      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW:0]     gain_q, gain_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            step;
  logic            muted_q, ramping_q;
  logic            cin;

  logic [DW-1:0]   samp_q [CH];
  logic [DW-1:0]   samp_d [CH];
  logic [DW-1:0]   v_q    [CH];
  logic [DW-1:0]   v_d    [CH];
  logic [DW:0]     acc_q  [CH];
  logic [DW:0]     acc_d  [CH];

  function automatic logic [DW-1:0] to_offset_f(input logic [DW-1:0] raw);
    return raw ^ SIGN_FLIP;
  endfunction

  // v = mid + ((u - mid) * gain) >>> GW; the result always fits DW bits unsigned
  function automatic logic [DW-1:0] scale_f(input logic [DW-1:0] u, input logic [GW:0] g);
    logic signed [DW:0]      d;
    logic signed [DW+GW+1:0] p;
    logic signed [DW+GW+1:0] v;
    d = $signed({1'b0, u}) - $signed({2'b01, {(DW-1){1'b0}}});
    p = (DW+GW+2)'(d) * (DW+GW+2)'($signed({1'b0, g}));
    v = (p >>> GW) + $signed({{(GW+2){1'b0}}, MID});
    return DW'(v);
  endfunction

  assign step = (div_q == DIV_LAST);

  // Gain FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_MUTED;
      gain_q    <= GAIN_ZERO;
      div_q     <= '0;
      muted_q   <= 1'b1;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      div_q     <= div_d;
      muted_q   <= (gain_q == GAIN_ZERO);
      ramping_q <= (gain_q != GAIN_ZERO) && (gain_q != GAIN_FULL);
    end
  end

  // Gain FSM: next state; a reversal at an end point lands directly in the rest state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MUTED: begin
        if (!mute) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (mute)
          state_d = (gain_q == GAIN_ZERO) ? ST_MUTED : ST_RAMP_DOWN;
        else if (step && gain_q == GAIN_TOP)
          state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (mute) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (!mute)
          state_d = (gain_q == GAIN_FULL) ? ST_PLAY : ST_RAMP_UP;
        else if (step && gain_q == GAIN_ONE)
          state_d = ST_MUTED;
      end
      default: state_d = ST_MUTED;
    endcase
  end

  // Gain FSM: gain and divider updates
  always_comb begin
    gain_d = gain_q;
    div_d  = '0;
    case (state_q)
      ST_RAMP_UP: begin
        if (!mute && step) gain_d = gain_q + GAIN_ONE;
      end
      ST_RAMP_DOWN: begin
        if (mute && step) gain_d = gain_q - GAIN_ONE;
      end
      default: gain_d = gain_q;
    endcase
    if ((state_d == state_q) && !step &&
        (state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN))
      div_d = div_q + DIV_ONE;
  end

  assign muted   = muted_q;
  assign ramping = ramping_q;

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      samp_d[k] = sample_cen ? to_offset_f(snd_in[k*DW +: DW]) : samp_q[k];
      v_d[k]    = scale_f(samp_q[k], gain_q);
      acc_d[k]  = {1'b0, acc_q[k][DW-1:0]} + {1'b0, v_q[k]} + {{DW{1'b0}}, cin};
    end
  end

  // Capture -> scale -> modulate, one register stage each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        samp_q[k] <= MID;
        v_q[k]    <= MID;
        acc_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        samp_q[k] <= samp_d[k];
        v_q[k]    <= v_d[k];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CH; k++) dac_out[k] = acc_q[k][DW];
  end

`ifdef JTFRAME_SDM_DITHER_EN
  // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting form
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_sdm_dac.sv
// Self-checking bench for jtframe_sdm_dac (CH=2, DW=16, GW=8, RAMP_DIV=4, signed input).
module tb_jtframe_sdm_dac;
  localparam int CH       = 2;
  localparam int DW       = 16;
  localparam int GW       = 8;
  localparam int RAMP_DIV = 4;
  localparam int NWIN     = 2048;

  typedef struct {
    int   edge_n;
    int   gain;
    logic muted;
    logic ramping;
  } ramp_vec_t;

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    int          v0;
    int          v1;
  } dens_vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sample_cen;
  logic [CH*DW-1:0] snd_in;
  logic            mute;
  logic [CH-1:0]   dac_out;
  logic            muted;
  logic            ramping;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_sdm_dac #(
    .CH(CH), .DW(DW), .SIGNED_SND(1), .GW(GW), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_cen(sample_cen), .snd_in(snd_in),
    .mute(mute), .dac_out(dac_out), .muted(muted), .ramping(ramping)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int gain_now();
    return int'(dut.gain_q);
  endfunction

  // Gain model after k edges of a ramp-down that started from full gain
  function automatic int gain_down_model(input int k);
    int g;
    if (k <= 0) return 256;
    g = 256 - (k - 1) / RAMP_DIV;
    return (g < 0) ? 0 : g;
  endfunction

  task automatic capture(input logic [15:0] s0, input logic [15:0] s1);
    snd_in     = {s1, s0};
    sample_cen = 1'b1;
    @(negedge clk);
    sample_cen = 1'b0;
  endtask

  task automatic count_ones(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(dac_out[0]);
      c1 += int'(dac_out[1]);
    end
  endtask

  // Ones over n clocks of a first-order modulator is floor/ceil(v*n/2^16), allowing 1 LSB slack
  task automatic check_density(input string name, input int c, input longint v);
    check_rng(name, c, (v * NWIN) / 65536 - 1, (v * NWIN + 65535) / 65536 + 1);
  endtask

  task automatic wait_gain(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (gain_now() == target) ok = 1'b1;
    end
  endtask

  // Hold mute for len sampling edges during RAMP_UP, release, then watch the climb resume
  task automatic mute_pulse(input int start_gain, input int len);
    int prev, g, maxd, expg;
    prev = gain_now();
    maxd = 0;
    mute = 1'b1;
    repeat (len) begin
      @(negedge clk);
      g = gain_now();
      if ((g - prev) > maxd) maxd = g - prev;
      if ((prev - g) > maxd) maxd = prev - g;
      prev = g;
    end
    mute = 1'b0;
    expg = start_gain - (len - 1) / RAMP_DIV;
    check("pulse_gain", gain_now(), expg);
    repeat (4) begin
      @(negedge clk);
      g = gain_now();
      if ((g - prev) > maxd) maxd = g - prev;
      if ((prev - g) > maxd) maxd = prev - g;
      prev = g;
    end
    check("resume_hold", gain_now(), expg);
    @(negedge clk);
    check("resume_step", gain_now(), expg + 1);
    check_rng("pulse_max_delta", maxd, 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1);
  end

  initial begin
    ramp_vec_t   rv [8];
    dens_vec_t   dv [5];
    int          e, c0, c1, cnt, prev_cnt, first_mute, len, target;
    longint      exp_num, u0, u1;
    logic [15:0] r0, r1;
    bit          ok;

    rv[0] = '{1,    0,   1'b1, 1'b0};
    rv[1] = '{4,    0,   1'b1, 1'b0};
    rv[2] = '{5,    1,   1'b1, 1'b0};
    rv[3] = '{6,    1,   1'b0, 1'b1};
    rv[4] = '{500,  124, 1'b0, 1'b1};
    rv[5] = '{1024, 255, 1'b0, 1'b1};
    rv[6] = '{1025, 256, 1'b0, 1'b1};
    rv[7] = '{1026, 256, 1'b0, 1'b0};

    dv[0] = '{16'h0000, 16'h8000, 32768, 0};
    dv[1] = '{16'h4000, 16'hC000, 49152, 16384};
    dv[2] = '{16'h7FFF, 16'h8001, 65535, 1};
    dv[3] = '{16'hFFFF, 16'h0001, 32767, 32769};
    dv[4] = '{16'h8000, 16'h7FFF, 0,     65535};

    rst_n      = 1'b0;
    mute       = 1'b0;
    sample_cen = 1'b0;
    snd_in     = '0;
    repeat (3) @(negedge clk);
    check("rst_dac_out", dac_out, 0);
    check("rst_muted", muted, 1);
    check("rst_ramping", ramping, 0);
    check("rst_gain", gain_now(), 0);

    // Ramp up from reset with mute low
    rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      while (e < rv[i].edge_n) begin
        @(negedge clk);
        e++;
      end
      check($sformatf("up_gain_e%0d", rv[i].edge_n), gain_now(), rv[i].gain);
      check($sformatf("up_muted_e%0d", rv[i].edge_n), muted, rv[i].muted);
      check($sformatf("up_ramping_e%0d", rv[i].edge_n), ramping, rv[i].ramping);
    end

    // Densities at full gain
    for (int i = 0; i < 5; i++) begin
      capture(dv[i].s0, dv[i].s1);
      repeat (4) @(negedge clk);
      count_ones(NWIN, c0, c1);
      check_density($sformatf("dens_vec%0d_ch0", i), c0, dv[i].v0);
      check_density($sformatf("dens_vec%0d_ch1", i), c1, dv[i].v1);
    end

    // Without sample_cen the latched samples hold
    snd_in = 32'h1234_5678;
    repeat (4) @(negedge clk);
    count_ones(NWIN, c0, c1);
    check_density("hold_ch0", c0, dv[4].v0);
    check_density("hold_ch1", c1, dv[4].v1);

    for (int i = 0; i < 6; i++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      u0 = longint'(r0 ^ 16'h8000);
      u1 = longint'(r1 ^ 16'h8000);
      capture(r0, r1);
      repeat (4) @(negedge clk);
      count_ones(NWIN, c0, c1);
      check_density($sformatf("rand%0d_ch0", i), c0, u0);
      check_density($sformatf("rand%0d_ch1", i), c1, u1);
    end

    // Two-clock latency: ch1 at v=0 emits no ones until the new sample reaches the accumulator
    capture(16'h0000, 16'h8000);
    repeat (8) @(negedge clk);
    snd_in     = {16'h7FFF, 16'h0000};
    sample_cen = 1'b1;
    @(negedge clk);
    sample_cen = 1'b0;
    check("lat_edge0", dac_out[1], 0);
    @(negedge clk);
    check("lat_edge1", dac_out[1], 0);
    count_ones(2, c0, c1);
    check_rng("lat_edge2_3", c1, 1, 2);

    // Soft mute from full gain with a near-full-scale sample
    capture(16'h7FFF, 16'h7FFF);
    repeat (4) @(negedge clk);
    mute       = 1'b1;
    e          = 0;
    first_mute = 0;
    prev_cnt   = 0;
    for (int w = 0; w < 5; w++) begin
      cnt     = 0;
      exp_num = 0;
      for (int j = 0; j < 256; j++) begin
        @(negedge clk);
        e++;
        cnt += int'(dac_out[0]);
        exp_num += 32768 + (longint'(32767) * gain_down_model(e - 2)) / 256;
        if (muted && first_mute == 0) first_mute = e;
      end
      check_rng($sformatf("down_win%0d", w), cnt, exp_num / 65536 - 2, exp_num / 65536 + 2);
      if (w > 0) check_rng($sformatf("down_mono%0d", w), cnt, 0, prev_cnt + 1);
      prev_cnt = cnt;
    end
    check("down_muted_edge", first_mute, 1026);
    check("down_gain_end", gain_now(), 0);
    check("down_ramping_end", ramping, 0);

    // Mute pulse in the middle of a ramp up
    mute = 1'b0;
    wait_gain(100, ok);
    check("reach_gain_100", ok, 1);
    if (ok) mute_pulse(100, 21);
    for (int t = 0; t < 5; t++) begin
      target = gain_now() + int'($urandom_range(3, 15));
      len    = int'($urandom_range(1, 40));
      wait_gain(target, ok);
      check($sformatf("reach_gain_t%0d", t), ok, 1);
      if (ok) mute_pulse(target, len);
    end

    // Asynchronous reset mid-ramp, checked before any clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dac_out", dac_out, 0);
    check("arst_gain", gain_now(), 0);
    check("arst_muted", muted, 1);
    check("arst_ramping", ramping, 0);
    mute = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_stay_muted", muted, 1);
    check("arst_stay_gain", gain_now(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
